// File: rtl/stream_width_downsizer_pkg.sv
// Shared definitions for the stream width downsizer: field-width helper and
// state encoding.
package stream_width_downsizer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Width needed to index 'value' items; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/stream_width_downsizer.sv
// Splits wide RxData words into BITWIDTH-bit beats, emitting RxBeats+1 beats
// per word with the packet-last flag on the final beat.
module stream_width_downsizer
  import stream_width_downsizer_pkg::*;
#(
  parameter  int BITWIDTH = 8,
  parameter  int RATIO    = 4,
  localparam int CNTW     = clog2(RATIO)
) (
  input  logic                      clki,
  input  logic                      rst,
  input  logic                      RxVld,
  input  logic [BITWIDTH*RATIO-1:0] RxData,
  input  logic [CNTW-1:0]           RxBeats,
  input  logic                      RxLast,
  output logic                      RxRdy,
  output logic                      TxVld,
  output logic [BITWIDTH-1:0]       TxData,
  output logic                      TxLast,
  input  logic                      TxRdy
);

  localparam logic [CNTW-1:0] MAX_IDX = CNTW'(RATIO - 1);

  function automatic logic [BITWIDTH-1:0] beat_slice(
    input logic [BITWIDTH*RATIO-1:0] word,
    input logic [CNTW-1:0]           k
  );
    return word[int'(k)*BITWIDTH +: BITWIDTH];
  endfunction

  function automatic logic [CNTW-1:0] clamp_beats(input logic [CNTW-1:0] beats);
    return (beats > MAX_IDX) ? MAX_IDX : beats;
  endfunction

  state_t                    state_q, state_d;
  logic [BITWIDTH*RATIO-1:0] word_q, word_d;
  logic [CNTW-1:0]           idx_q, idx_d;
  logic [CNTW-1:0]           cnt_q, cnt_d;
  logic                      last_q, last_d;

  logic busy;
  logic at_end;
  logic fin;
  logic accept;

  always_comb begin
    busy   = (state_q == ST_EMIT);
    at_end = (idx_q == cnt_q);
    fin    = busy & TxRdy & at_end;
    accept = RxVld & ~rst & (~busy | fin);

    TxVld  = busy;
    TxData = beat_slice(word_q, idx_q);
    TxLast = busy & last_q & at_end;
    RxRdy  = ~rst & (~busy | fin);

    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    last_d  = last_q;

    // A new word overrides the end-of-word return to idle, so back-to-back
    // words stream without a bubble.
    if (accept) begin
      state_d = ST_EMIT;
      word_d  = RxData;
      idx_d   = '0;
      cnt_d   = clamp_beats(RxBeats);
      last_d  = RxLast;
    end else if (fin) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else if (busy & TxRdy) begin
      idx_d = idx_q + CNTW'(1);
    end
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clki) begin
    word_q <= word_d;
  end

endmodule

// File: tb/tb_stream_width_downsizer.sv
// Bench for stream_width_downsizer: directed scenarios plus a randomized run
// scored against a queue of owed output beats.
module tb_stream_width_downsizer;

  logic        clk;
  logic        rst;

  logic        rx_vld;
  logic [31:0] rx_data;
  logic [1:0]  rx_beats;
  logic        rx_last;
  logic        rx_rdy;
  logic        tx_vld;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        tx_rdy;

  logic        rx_vld3;
  logic [23:0] rx_data3;
  logic [1:0]  rx_beats3;
  logic        rx_last3;
  logic        rx_rdy3;
  logic        tx_vld3;
  logic [7:0]  tx_data3;
  logic        tx_last3;
  logic        tx_rdy3;

  int n_checks;
  int n_errors;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  stream_width_downsizer #(.BITWIDTH(8), .RATIO(4)) dut (
    .clki(clk), .rst(rst),
    .RxVld(rx_vld), .RxData(rx_data), .RxBeats(rx_beats), .RxLast(rx_last),
    .RxRdy(rx_rdy),
    .TxVld(tx_vld), .TxData(tx_data), .TxLast(tx_last), .TxRdy(tx_rdy)
  );

  stream_width_downsizer #(.BITWIDTH(8), .RATIO(3)) dut3 (
    .clki(clk), .rst(rst),
    .RxVld(rx_vld3), .RxData(rx_data3), .RxBeats(rx_beats3), .RxLast(rx_last3),
    .RxRdy(rx_rdy3),
    .TxVld(tx_vld3), .TxData(tx_data3), .TxLast(tx_last3), .TxRdy(tx_rdy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 unit later.
  task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] b,
                       input logic l, input logic tr);
    rx_vld   = v;
    rx_data  = d;
    rx_beats = b;
    rx_last  = l;
    tx_rdy   = tr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
      #1;
      n_checks++;
      if (tx_vld !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_txvld cyc%0d: got %b expected 0", i, tx_vld);
      end
      n_checks++;
      if (rx_rdy !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_rxrdy cyc%0d: got %b expected 0", i, rx_rdy);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({rx_rdy, tx_vld, tx_last} !== 3'b100) begin
      n_errors++;
      $display("FAIL post_reset rdy/vld/last: got %b expected 100", {rx_rdy, tx_vld, tx_last});
    end
  endtask

  task automatic test_full_word();
    logic [7:0] exp_d [4];
    exp_d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    @(negedge clk);
    drive(1'b1, 32'hDDCCBBAA, 2'd3, 1'b1, 1'b1);
    #1;
    n_checks++;
    if (rx_rdy !== 1'b1) begin
      n_errors++;
      $display("FAIL full_accept_rdy: got %b expected 1", rx_rdy);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
      #1;
      n_checks++;
      if ({tx_vld, tx_data, tx_last, rx_rdy} !== {1'b1, exp_d[k], k == 3, k == 3}) begin
        n_errors++;
        $display("FAIL full_beat%0d vld/data/last/rdy: got %b/%h/%b/%b expected 1/%h/%b/%b",
                 k, tx_vld, tx_data, tx_last, rx_rdy, exp_d[k], k == 3, k == 3);
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (tx_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL full_idle_after: got %b expected 0", tx_vld);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(1'b1, 32'h03020100, 2'd3, 1'b0, 1'b1);
    #1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 4) drive(1'b1, 32'h07060504, 2'd3, 1'b1, 1'b1);
      else       drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
      #1;
      n_checks++;
      if ({tx_vld, tx_data, tx_last, rx_rdy} !== {1'b1, 8'(k), k == 7, (k == 3) || (k == 7)}) begin
        n_errors++;
        $display("FAIL b2b_beat%0d vld/data/last/rdy: got %b/%h/%b/%b expected 1/%h/%b/%b",
                 k, tx_vld, tx_data, tx_last, rx_rdy, 8'(k), k == 7, (k == 3) || (k == 7));
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (tx_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_idle_after: got %b expected 0", tx_vld);
    end
  endtask

  task automatic test_short();
    @(negedge clk);
    drive(1'b1, 32'hDDCCBBAA, 2'd1, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
      #1;
      n_checks++;
      if ({tx_vld, tx_data, tx_last, rx_rdy} !== {1'b1, (k == 0) ? 8'hAA : 8'hBB, k == 1, k == 1}) begin
        n_errors++;
        $display("FAIL short_beat%0d vld/data/last/rdy: got %b/%h/%b/%b", k, tx_vld, tx_data, tx_last, rx_rdy);
      end
    end
    // Single-beat word without packet end.
    drive(1'b1, 32'h11223344, 2'd0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if ({tx_vld, tx_data, tx_last, rx_rdy} !== {1'b1, 8'h44, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL single_beat vld/data/last/rdy: got %b/%h/%b/%b expected 1/44/0/1",
               tx_vld, tx_data, tx_last, rx_rdy);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (tx_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL single_idle_after: got %b expected 0", tx_vld);
    end
  endtask

  task automatic test_clamp();
    logic [7:0] exp_d [3];
    exp_d = '{8'hAA, 8'hBB, 8'hCC};
    @(negedge clk);
    rx_vld3 = 1'b1; rx_data3 = 24'hCCBBAA; rx_beats3 = 2'd3; rx_last3 = 1'b1; tx_rdy3 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rx_vld3 = 1'b0;
      #1;
      n_checks++;
      if ({tx_vld3, tx_data3, tx_last3} !== {1'b1, exp_d[k], k == 2}) begin
        n_errors++;
        $display("FAIL clamp_beat%0d vld/data/last: got %b/%h/%b expected 1/%h/%b",
                 k, tx_vld3, tx_data3, tx_last3, exp_d[k], k == 2);
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (tx_vld3 !== 1'b0) begin
      n_errors++;
      $display("FAIL clamp_idle_after: got %b expected 0", tx_vld3);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    drive(1'b1, 32'hDDCCBBAA, 2'd3, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (tx_data !== 8'hAA) begin
      n_errors++;
      $display("FAIL bp_first: got %h expected aa", tx_data);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tx_rdy = 1'b0;
      #1;
      n_checks++;
      if ({tx_vld, tx_data, tx_last, rx_rdy} !== {1'b1, 8'hBB, 1'b0, 1'b0}) begin
        n_errors++;
        $display("FAIL bp_stall%0d vld/data/last/rdy: got %b/%h/%b/%b expected 1/bb/0/0",
                 i, tx_vld, tx_data, tx_last, rx_rdy);
      end
    end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      tx_rdy = 1'b1;
      #1;
      n_checks++;
      if ({tx_vld, tx_data, tx_last, rx_rdy} !== {1'b1, 8'hAA + 8'(k * 17), k == 3, k == 3}) begin
        n_errors++;
        $display("FAIL bp_resume%0d vld/data/last/rdy: got %b/%h/%b/%b", k, tx_vld, tx_data, tx_last, rx_rdy);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    @(negedge clk);
    drive(1'b1, 32'hDDCCBBAA, 2'd3, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    n_checks++;
    if (tx_data !== 8'hBB) begin
      n_errors++;
      $display("FAIL rmw_bb: got %h expected bb", tx_data);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (rx_rdy !== 1'b0) begin
      n_errors++;
      $display("FAIL rmw_rdy_in_reset: got %b expected 0", rx_rdy);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 32'h44332211, 2'd3, 1'b1, 1'b1);
    #1;
    n_checks++;
    if ({tx_vld, rx_rdy} !== 2'b01) begin
      n_errors++;
      $display("FAIL rmw_after_reset vld/rdy: got %b expected 01", {tx_vld, rx_rdy});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
      #1;
      n_checks++;
      if ({tx_vld, tx_data, tx_last} !== {1'b1, 8'h11 * 8'(k + 1), k == 3}) begin
        n_errors++;
        $display("FAIL rmw_new_beat%0d vld/data/last: got %b/%h/%b", k, tx_vld, tx_data, tx_last);
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_random();
    beat_t q[$];
    logic  pend;
    logic  exp_vld;
    logic  exp_rdy;
    pend = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!pend) begin
        if ($urandom_range(0, 2) != 0)
          drive(1'b1, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        else
          rx_vld = 1'b0;
      end
      tx_rdy = ($urandom_range(0, 3) != 0);
      #1;
      exp_vld = (q.size() != 0);
      exp_rdy = (q.size() == 0) || ((q.size() == 1) && tx_rdy);
      n_checks++;
      if (tx_vld !== exp_vld) begin
        n_errors++;
        $display("FAIL rand_txvld cyc%0d: got %b expected %b", cyc, tx_vld, exp_vld);
      end
      n_checks++;
      if (rx_rdy !== exp_rdy) begin
        n_errors++;
        $display("FAIL rand_rxrdy cyc%0d: got %b expected %b", cyc, rx_rdy, exp_rdy);
      end
      if (exp_vld) begin
        n_checks++;
        if ({tx_data, tx_last} !== {q[0].d, q[0].l}) begin
          n_errors++;
          $display("FAIL rand_beat cyc%0d data/last: got %h/%b expected %h/%b",
                   cyc, tx_data, tx_last, q[0].d, q[0].l);
        end
      end
      if (exp_vld && tx_rdy) void'(q.pop_front());
      if (rx_vld && exp_rdy) begin
        for (int k = 0; k <= int'(rx_beats); k++)
          q.push_back('{d: rx_data[k*8 +: 8], l: rx_last && (k == int'(rx_beats))});
        pend = 1'b0;
      end else begin
        pend = rx_vld;
      end
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
    rx_vld3   = 1'b0;
    rx_data3  = 24'h0;
    rx_beats3 = 2'd0;
    rx_last3  = 1'b0;
    tx_rdy3   = 1'b1;

    test_reset();
    test_full_word();
    test_back_to_back();
    test_short();
    test_clamp();
    test_backpressure();
    test_reset_mid_word();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
